sid_wave_table_arbiter: RTL and testbench

//  Shares one combined-waveform ROM port among the three SID voices.
//  The port serves the pulse/saw, pulse/tri, saw/tri and pulse/saw/tri tables, addressed by a 12-bit wave

---
 rtl/sid_wave_table_arbiter.sv | 109 ++++++++++
 tb/tb_sid_wave_table_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sid_wave_table_arbiter.sv
// rtl/sid_wave_table_arbiter.sv - round-robin share of one combined-waveform ROM port among three SID voices
// Results come back through a fixed-latency tag pipeline and land in per-voice held registers.
module sid_wave_table_arbiter #(
  parameter int ROM_LATENCY = 1,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] wave0,
  input  logic [ADDR_W-1:0] wave1,
  input  logic [ADDR_W-1:0] wave2,
  input  logic [1:0]        sel0,
  input  logic [1:0]        sel1,
  input  logic [1:0]        sel2,
  output logic [2:0]        grant,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_wave,
  output logic [1:0]        rom_sel,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [2:0]        valid
);

  logic [2:0]                   busy;
  logic [1:0]                   ptr;
  logic [3:0]                   elig;
  logic [2:0]                   cand;
  logic                         pick_vld;
  logic [1:0]                   pick_v;
  logic [2:0]                   pick_oh;
  logic [ADDR_W-1:0]            pick_wave;
  logic [1:0]                   pick_sel;
  logic [1:0]                   issue_voice;
  logic [ROM_LATENCY-1:0]       tag_vld;
  logic [ROM_LATENCY-1:0][1:0]  tag_voice;

  assign elig = {1'b0, req & ~busy};

  // Scan ptr, ptr+1, ptr+2 (mod 3); the first eligible voice wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_v   = 2'd0;
    cand     = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, ptr} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!pick_vld && elig[cand[1:0]]) begin
        pick_vld = 1'b1;
        pick_v   = cand[1:0];
      end
    end
  end

  always_comb begin
    pick_oh   = 3'b000;
    pick_wave = wave0;
    pick_sel  = sel0;
    case (pick_v)
      2'd1:    begin pick_wave = wave1; pick_sel = sel1; end
      2'd2:    begin pick_wave = wave2; pick_sel = sel2; end
      default: begin pick_wave = wave0; pick_sel = sel0; end
    endcase
    if (pick_vld) pick_oh = 3'b001 << pick_v;
  end

  assign issue_voice = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);

  // The last tag stage lines up with rom_data, so valid is decoded straight from it.
  assign valid = tag_vld[ROM_LATENCY-1] ? (3'b001 << tag_voice[ROM_LATENCY-1]) : 3'b000;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant     <= 3'b000;
      rom_en    <= 1'b0;
      rom_wave  <= '0;
      rom_sel   <= 2'd0;
      busy      <= 3'b000;
      ptr       <= 2'd0;
      tag_vld   <= '0;
      tag_voice <= '0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
    end else begin
      grant  <= pick_oh;
      rom_en <= pick_vld;
      if (pick_vld) begin
        rom_wave <= pick_wave;
        rom_sel  <= pick_sel;
        ptr      <= (pick_v == 2'd2) ? 2'd0 : pick_v + 2'd1;
      end
      busy <= (busy & ~valid) | pick_oh;
      for (int i = ROM_LATENCY - 1; i > 0; i--) begin
        tag_vld[i]   <= tag_vld[i-1];
        tag_voice[i] <= tag_voice[i-1];
      end
      tag_vld[0]   <= rom_en;
      tag_voice[0] <= issue_voice;
      if (valid[0]) out0 <= rom_data;
      if (valid[1]) out1 <= rom_data;
      if (valid[2]) out2 <= rom_data;
    end
  end

endmodule

// File: tb/tb_sid_wave_table_arbiter.sv
// tb/tb_sid_wave_table_arbiter.sv - scoreboard bench for sid_wave_table_arbiter
// Reference model schedules grants/results per cycle from the arbitration rules; a monitor compares.
module tb_sid_wave_table_arbiter;

  localparam int L  = 3;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [2:0]    req;
  logic [AW-1:0] wave0, wave1, wave2;
  logic [1:0]    sel0, sel1, sel2;
  logic [2:0]    grant;
  logic          rom_en;
  logic [AW-1:0] rom_wave;
  logic [1:0]    rom_sel;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out0, out1, out2;
  logic [2:0]    valid;

  always #5 clock = ~clock;

  sid_wave_table_arbiter #(.ROM_LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .wave0(wave0), .wave1(wave1), .wave2(wave2),
    .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .grant(grant), .rom_en(rom_en), .rom_wave(rom_wave), .rom_sel(rom_sel),
    .rom_data(rom_data), .out0(out0), .out1(out1), .out2(out2), .valid(valid)
  );

  typedef struct packed {
    int            cyc;
    int            v;
    logic [AW-1:0] w;
    logic [1:0]    s;
    logic [DW-1:0] d;
  } ev_t;

  typedef struct packed {
    logic          en;
    logic [1:0]    s;
    logic [AW-1:0] w;
  } rp_t;

  logic [DW-1:0] rom_mem [4][4096];
  ev_t           gq[$];
  ev_t           vq[$];
  ev_t           uq[$];
  rp_t           rpipe [L+1];
  int            cyc = 0;
  int            free_at [3];
  int            ptr_m = 0;
  logic [DW-1:0] exp_out [3];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] wave_of(input int v);
    return (v == 0) ? wave0 : ((v == 1) ? wave1 : wave2);
  endfunction

  function automatic logic [1:0] sel_of(input int v);
    return (v == 0) ? sel0 : ((v == 1) ? sel1 : sel2);
  endfunction

  // Reference model: evaluates the cycle that is ending at this edge.
  always @(posedge clock) begin
    automatic int  t = cyc;
    automatic ev_t e;
    automatic int  v;
    if (reset_n !== 1'b1) begin
      gq.delete();
      vq.delete();
      uq.delete();
      for (int k = 0; k < 3; k++) begin
        free_at[k] = 0;
        exp_out[k] = '0;
      end
      ptr_m = 0;
    end else begin
      if (uq.size() > 0 && uq[0].cyc == t) begin
        exp_out[uq[0].v] = uq[0].d;
        void'(uq.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
        v = (ptr_m + k) % 3;
        if (req[v] && t >= free_at[v]) begin
          e.cyc = t + 1;
          e.v   = v;
          e.w   = wave_of(v);
          e.s   = sel_of(v);
          e.d   = rom_mem[e.s][e.w];
          gq.push_back(e);
          e.cyc = t + 1 + L;
          vq.push_back(e);
          uq.push_back(e);
          free_at[v] = t + L + 2;
          ptr_m = (v + 1) % 3;
          break;
        end
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: compares the DUT outputs of the current cycle against scheduled events.
  always @(negedge clock) begin
    automatic ev_t e;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      e = gq.pop_front();
      chk("grant", 64'(grant), 64'(3'b001 << e.v));
      chk("rom_en", 64'(rom_en), 64'(1'b1));
      chk("rom_wave", 64'(rom_wave), 64'(e.w));
      chk("rom_sel", 64'(rom_sel), 64'(e.s));
    end else begin
      chk("grant_idle", 64'(grant), 64'(3'b000));
      chk("rom_en_idle", 64'(rom_en), 64'(1'b0));
    end
    if (vq.size() > 0 && vq[0].cyc == cyc) begin
      e = vq.pop_front();
      chk("valid", 64'(valid), 64'(3'b001 << e.v));
    end else begin
      chk("valid_idle", 64'(valid), 64'(3'b000));
    end
    chk("out0", 64'(out0), 64'(exp_out[0]));
    chk("out1", 64'(out1), 64'(exp_out[1]));
    chk("out2", 64'(out2), 64'(exp_out[2]));
  end

  // ROM model: returns the addressed byte L cycles after rom_en, garbage otherwise.
  always @(negedge clock) begin
    for (int i = L; i > 0; i--) rpipe[i] = rpipe[i-1];
    rpipe[0] = {rom_en, rom_sel, rom_wave};
    if (rpipe[L].en === 1'b1) rom_data = rom_mem[rpipe[L].s][rpipe[L].w];
    else                      rom_data = 8'($urandom);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 4096; a++) rom_mem[s][a] = 8'($urandom);
    rom_mem[0][12'h7FF] = 8'hFF;
    rom_mem[2][12'h123] = 8'hAB;
    rom_mem[3][12'hFF0] = 8'h5C;
    rom_mem[2][12'h3FF] = 8'hA3;
    for (int i = 0; i <= L; i++) rpipe[i] = '0;

    reset_n = 1'b0;
    req = 3'b111;
    wave0 = 12'h111; wave1 = 12'h222; wave2 = 12'h333;
    sel0 = 2'd0; sel1 = 2'd1; sel2 = 2'd2;
    rom_data = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Round-robin with all voices requesting.
    step(16);

    // Single voice lookup.
    req = 3'b000; step(8);
    req = 3'b010; wave1 = 12'h7FF; sel1 = 2'd0; step(1);
    req = 3'b000; step(8);

    // One voice held: spacing limited by its own busy window.
    req = 3'b001; wave0 = 12'h0A5; sel0 = 2'd1; step(20);
    req = 3'b000; step(8);

    // Reset while a lookup is in flight.
    req = 3'b100; wave2 = 12'h123; sel2 = 2'd2; step(1);
    req = 3'b000; step(1);
    reset_n = 1'b0; step(1);
    reset_n = 1'b1; step(8);

    // Table routing for two voices at once.
    req = 3'b101; wave0 = 12'hFF0; sel0 = 2'd3; wave2 = 12'h3FF; sel2 = 2'd2; step(2);
    req = 3'b000; step(10);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      req   = 3'($urandom);
      wave0 = 12'($urandom); wave1 = 12'($urandom); wave2 = 12'($urandom);
      sel0  = 2'($urandom);  sel1  = 2'($urandom);  sel2  = 2'($urandom);
      reset_n = ($urandom_range(0, 199) != 0);
      step(1);
    end
    reset_n = 1'b1;
    req = 3'b000;
    step(12);

    chk("drain_grant_q", 64'(gq.size()), 64'(0));
    chk("drain_valid_q", 64'(vq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
